// File: rtl/tft_rx_monitor.sv
// tft_rx_monitor: oversampling TFT RGB/HSYNC/VSYNC/DE receiver with pixel recovery, timing measurement and lock tracking
module tft_rx_monitor #(
  parameter int EXP_H_TOTAL  = 939,
  parameter int EXP_H_ACTIVE = 800,
  parameter int EXP_V_TOTAL  = 555,
  parameter int EXP_V_ACTIVE = 480,
  parameter int TIMEOUT      = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pxclk_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        de_in,
  input  logic [7:0]  r_in,
  input  logic [7:0]  g_in,
  input  logic [7:0]  b_in,
  input  logic        err_clear,
  output logic        pix_valid,
  output logic [9:0]  pix_x,
  output logic [8:0]  pix_y,
  output logic [23:0] pix_rgb,
  output logic        line_start,
  output logic        frame_start,
  output logic [11:0] h_total,
  output logic [11:0] h_active,
  output logic [11:0] v_total,
  output logic [11:0] v_active,
  output logic        locked,
  output logic        err_sticky
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [11:0] EHT = 12'(EXP_H_TOTAL);
  localparam logic [11:0] EHA = 12'(EXP_H_ACTIVE);
  localparam logic [11:0] EVT = 12'(EXP_V_TOTAL);
  localparam logic [11:0] EVA = 12'(EXP_V_ACTIVE);
  typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;
  state_t state_q, state_d;
  logic [27:0] s1_q, s1_d, s2_q, s2_d;
  logic px_prev_q, px_prev_d, hs_prev_q, hs_prev_d, vs_prev_q, vs_prev_d;
  logic first_q, first_d, had_q, had_d, bad_q, bad_d, err_q, err_d;
  logic [11:0] h_cnt_q, h_cnt_d, de_cnt_q, de_cnt_d, v_cnt_q, v_cnt_d, va_cnt_q, va_cnt_d;
  logic [11:0] h_total_q, h_total_d, h_active_q, h_active_d, v_total_q, v_total_d, v_active_q, v_active_d;
  logic [9:0] x_q, x_d, pix_x_q, pix_x_d;
  logic [8:0] y_q, y_d, pix_y_q, pix_y_d;
  logic [23:0] pix_rgb_q, pix_rgb_d;
  logic pix_valid_q, pix_valid_d, line_start_q, line_start_d, frame_start_q, frame_start_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic tick, hs_fall, vs_fall, tmo_hit, line_chk, v_chk, err_set;

  function automatic logic [11:0] inc12(input logic [11:0] a);
    return (a == 12'hFFF) ? a : a + 12'd1;
  endfunction

  // Edge detection on the synchronised stream, line/frame counting, lock FSM next state
  always_comb begin
    s1_d = {pxclk_in, hsync_in, vsync_in, de_in, r_in, g_in, b_in};
    s2_d = s1_q;
    px_prev_d = s2_q[27];
    tick = s2_q[27] & ~px_prev_q;
    hs_fall = tick & hs_prev_q & ~s2_q[26];
    vs_fall = tick & vs_prev_q & ~s2_q[25];
    tmo_hit = ~tick & (tmo_q == TMO_LAST);
    tmo_d = (tick | tmo_hit) ? '0 : tmo_q + TW'(1);
    state_d = state_q;
    hs_prev_d = hs_prev_q;
    vs_prev_d = vs_prev_q;
    first_d = first_q;
    had_d = had_q;
    bad_d = bad_q;
    h_cnt_d = h_cnt_q;
    de_cnt_d = de_cnt_q;
    v_cnt_d = v_cnt_q;
    va_cnt_d = va_cnt_q;
    h_total_d = h_total_q;
    h_active_d = h_active_q;
    v_total_d = v_total_q;
    v_active_d = v_active_q;
    x_d = x_q;
    y_d = y_q;
    pix_x_d = pix_x_q;
    pix_y_d = pix_y_q;
    pix_rgb_d = pix_rgb_q;
    pix_valid_d = 1'b0;
    line_start_d = 1'b0;
    frame_start_d = 1'b0;
    line_chk = 1'b0;
    v_chk = 1'b0;
    err_set = 1'b0;
    if (tmo_hit) begin
      state_d = SEARCH;
      first_d = 1'b1;
      had_d = 1'b0;
      bad_d = 1'b0;
      h_cnt_d = '0;
      de_cnt_d = '0;
      v_cnt_d = '0;
      va_cnt_d = '0;
      x_d = '0;
      y_d = '0;
      err_set = state_q == LOCKED;
    end else if (tick) begin
      hs_prev_d = s2_q[26];
      vs_prev_d = s2_q[25];
      h_cnt_d = inc12(h_cnt_q);
      if (s2_q[24]) begin
        pix_valid_d = (state_q == LOCKED) && ({2'b0, x_q} < EHA) && ({3'b0, y_q} < EVA);
        pix_x_d = pix_valid_d ? x_q : pix_x_q;
        pix_y_d = pix_valid_d ? y_q : pix_y_q;
        pix_rgb_d = pix_valid_d ? s2_q[23:0] : pix_rgb_q;
        de_cnt_d = inc12(de_cnt_q);
        x_d = (x_q == '1) ? x_q : x_q + 10'd1;
        had_d = 1'b1;
      end
      if (hs_fall) begin
        line_start_d = state_q != SEARCH;
        line_chk = ~first_q & ((h_cnt_q != EHT) | (had_q & (de_cnt_q != EHA)));
        h_total_d = first_q ? h_total_q : h_cnt_q;
        h_active_d = (first_q | ~had_q) ? h_active_q : de_cnt_q;
        v_cnt_d = inc12(v_cnt_q);
        va_cnt_d = had_q ? inc12(va_cnt_q) : va_cnt_q;
        y_d = (had_q && y_q != '1) ? y_q + 9'd1 : y_q;
        first_d = 1'b0;
        h_cnt_d = 12'd1;
        de_cnt_d = '0;
        x_d = '0;
        had_d = 1'b0;
        bad_d = bad_q | line_chk;
        state_d = (line_chk && state_q == LOCKED) ? MEASURE : state_q;
        err_set = line_chk && state_q == LOCKED;
      end
      if (vs_fall) begin
        frame_start_d = state_q != SEARCH;
        v_chk = (v_cnt_d != EVT) | (va_cnt_d != EVA);
        v_total_d = (state_q == SEARCH) ? v_total_q : v_cnt_d;
        v_active_d = (state_q == SEARCH) ? v_active_q : va_cnt_d;
        if (state_q == SEARCH) state_d = MEASURE;
        else if (state_q == MEASURE)
          state_d = (~bad_d & ~v_chk & (h_total_d == EHT) & (h_active_d == EHA)) ? LOCKED : MEASURE;
        else if (v_chk) begin
          state_d = MEASURE;
          err_set = 1'b1;
        end
        v_cnt_d = '0;
        va_cnt_d = '0;
        y_d = '0;
        bad_d = 1'b0;
      end
    end
    err_d = err_set | (err_q & ~err_clear);
  end

  // All state, including the input synchroniser, with asynchronous active-low reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= SEARCH;
      s1_q <= '0;
      s2_q <= '0;
      px_prev_q <= 1'b0;
      hs_prev_q <= 1'b0;
      vs_prev_q <= 1'b0;
      first_q <= 1'b1;
      had_q <= 1'b0;
      bad_q <= 1'b0;
      err_q <= 1'b0;
      h_cnt_q <= '0;
      de_cnt_q <= '0;
      v_cnt_q <= '0;
      va_cnt_q <= '0;
      h_total_q <= '0;
      h_active_q <= '0;
      v_total_q <= '0;
      v_active_q <= '0;
      x_q <= '0;
      y_q <= '0;
      pix_x_q <= '0;
      pix_y_q <= '0;
      pix_rgb_q <= '0;
      pix_valid_q <= 1'b0;
      line_start_q <= 1'b0;
      frame_start_q <= 1'b0;
      tmo_q <= '0;
    end else begin
      state_q <= state_d;
      s1_q <= s1_d;
      s2_q <= s2_d;
      px_prev_q <= px_prev_d;
      hs_prev_q <= hs_prev_d;
      vs_prev_q <= vs_prev_d;
      first_q <= first_d;
      had_q <= had_d;
      bad_q <= bad_d;
      err_q <= err_d;
      h_cnt_q <= h_cnt_d;
      de_cnt_q <= de_cnt_d;
      v_cnt_q <= v_cnt_d;
      va_cnt_q <= va_cnt_d;
      h_total_q <= h_total_d;
      h_active_q <= h_active_d;
      v_total_q <= v_total_d;
      v_active_q <= v_active_d;
      x_q <= x_d;
      y_q <= y_d;
      pix_x_q <= pix_x_d;
      pix_y_q <= pix_y_d;
      pix_rgb_q <= pix_rgb_d;
      pix_valid_q <= pix_valid_d;
      line_start_q <= line_start_d;
      frame_start_q <= frame_start_d;
      tmo_q <= tmo_d;
    end
  end

  assign pix_valid = pix_valid_q;
  assign pix_x = pix_x_q;
  assign pix_y = pix_y_q;
  assign pix_rgb = pix_rgb_q;
  assign line_start = line_start_q;
  assign frame_start = frame_start_q;
  assign h_total = h_total_q;
  assign h_active = h_active_q;
  assign v_total = v_total_q;
  assign v_active = v_active_q;
  assign locked = state_q == LOCKED;
  assign err_sticky = err_q;
endmodule

// File: tb/tb_tft_rx_monitor.sv
// tb_tft_rx_monitor: frame-table stimulus for tft_rx_monitor with a pixel scoreboard on a reduced raster
module tb_tft_rx_monitor;
  localparam int HT = 20, HA = 8, VT = 12, VA = 6, DE_LINE = 3, DE_TICK = 6, TMO = 64, HALF = 4;
  logic clk = 0, reset = 0, pxclk_in = 0, hsync_in = 1, vsync_in = 1, de_in = 0, err_clear = 0;
  logic [7:0] r_in = 0, g_in = 0, b_in = 0;
  logic pix_valid, line_start, frame_start, locked, err_sticky;
  logic [9:0] pix_x;
  logic [8:0] pix_y;
  logic [23:0] pix_rgb;
  logic [11:0] h_total, h_active, v_total, v_active;
  logic [42:0] sb[$];
  logic [42:0] exp_px;
  int n_vec = 0, n_err = 0;

  typedef struct {
    int stall; int last_len; int extra_line; int valid_lines;
    bit clr_start; bit clr_after; bit locked; bit err;
    int ht; int ha; int vt; int va;
  } vec_t;
  vec_t tab[12];

  tft_rx_monitor #(.EXP_H_TOTAL(HT), .EXP_H_ACTIVE(HA), .EXP_V_TOTAL(VT), .EXP_V_ACTIVE(VA), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .pxclk_in(pxclk_in), .hsync_in(hsync_in), .vsync_in(vsync_in), .de_in(de_in),
    .r_in(r_in), .g_in(g_in), .b_in(b_in), .err_clear(err_clear), .pix_valid(pix_valid), .pix_x(pix_x),
    .pix_y(pix_y), .pix_rgb(pix_rgb), .line_start(line_start), .frame_start(frame_start), .h_total(h_total),
    .h_active(h_active), .v_total(v_total), .v_active(v_active), .locked(locked), .err_sticky(err_sticky));

  always #4 clk = ~clk;

  function automatic vec_t mk(input int st, input int ll, input int ex, input int vl, input bit cs, input bit ca,
                              input bit lk, input bit er, input int eht, input int eha, input int evt, input int eva);
    vec_t r;
    r.stall = st; r.last_len = ll; r.extra_line = ex; r.valid_lines = vl;
    r.clr_start = cs; r.clr_after = ca; r.locked = lk; r.err = er;
    r.ht = eht; r.ha = eha; r.vt = evt; r.va = eva;
    return r;
  endfunction

  task automatic check(input string name, input int fr, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s frame %0d: got %0d, required %0d", name, fr, act, exp);
    end
  endtask

  task automatic check_vec(input vec_t v, input int fr);
    check("locked", fr, locked, v.locked);
    check("err_sticky", fr, err_sticky, v.err);
    check("h_total", fr, h_total, v.ht);
    check("h_active", fr, h_active, v.ha);
    check("v_total", fr, v_total, v.vt);
    check("v_active", fr, v_active, v.va);
    if (v.clr_after) begin
      @(negedge clk); err_clear = 1;
      @(negedge clk); err_clear = 0;
      @(negedge clk);
      check("err_clear_alone", fr, err_sticky, 0);
    end
  endtask

  // One pxclk period: data changes with the falling edge, err_clear optionally spans the output edge
  task automatic tick(input logic hs, input logic vs, input logic de, input logic [23:0] rgb, input bit clr);
    @(negedge clk);
    pxclk_in = 0; hsync_in = hs; vsync_in = vs; de_in = de; {r_in, g_in, b_in} = rgb;
    repeat (HALF - 1) @(negedge clk);
    @(negedge clk);
    pxclk_in = 1;
    if (clr) begin
      @(negedge clk); err_clear = 1;
      repeat (2) @(negedge clk);
      err_clear = 0;
      @(negedge clk);
    end else repeat (HALF) @(negedge clk);
  endtask

  task automatic drive_frame(input vec_t v, input int fr, input int n_lines, input bit do_chk);
    for (int l = 0; l < n_lines; l++) begin
      int len = (l == VT - 1) ? v.last_len : HT;
      int dl = l - DE_LINE;
      bit act = dl >= 0 && dl < VA;
      int nde = !act ? 0 : (l == v.extra_line ? HA + 1 : HA);
      for (int t = 0; t < len; t++) begin
        bit de = t >= DE_TICK && t < DE_TICK + nde;
        logic [23:0] rgb = de ? 24'($urandom) : 24'h0;
        if (de && dl < v.valid_lines && t - DE_TICK < HA) sb.push_back({10'(t - DE_TICK), 9'(dl), rgb});
        tick(t >= 2, l >= 2, de, rgb, v.clr_start && l == 0 && t == 0);
        if (do_chk && l == 0 && t == 0) check_vec(v, fr);
      end
    end
  endtask

  always @(negedge clk) begin
    if (reset && pix_valid) begin
      n_vec++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_pixel: got x=%0d y=%0d, required no pixel", pix_x, pix_y);
      end else begin
        exp_px = sb.pop_front();
        if ({pix_x, pix_y, pix_rgb} != exp_px) begin
          n_err++;
          $display("FAIL pixel: got x=%0d y=%0d rgb=%06h, required x=%0d y=%0d rgb=%06h",
                   pix_x, pix_y, pix_rgb, exp_px[42:33], exp_px[32:24], exp_px[23:0]);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not end, required $finish");
    $fatal(1);
  end

  initial begin
    tab[0]  = mk(0,       HT,     -1,               0,  0, 0, 0, 0, 0,      0,      0,  0);
    tab[1]  = mk(0,       HT,     -1,               0,  0, 0, 0, 0, HT,     HA,     0,  0);
    tab[2]  = mk(0,       HT,     -1,               VA, 0, 0, 1, 0, HT,     HA,     VT, VA);
    tab[3]  = mk(0,       HT - 1, -1,               VA, 0, 0, 1, 0, HT,     HA,     VT, VA);
    tab[4]  = mk(0,       HT,     -1,               0,  1, 1, 0, 1, HT - 1, HA,     VT, VA);
    tab[5]  = mk(0,       HT,     DE_LINE + VA - 1, VA, 0, 0, 1, 0, HT,     HA,     VT, VA);
    tab[6]  = mk(0,       HT,     -1,               0,  0, 0, 0, 1, HT,     HA + 1, VT, VA);
    tab[7]  = mk(0,       HT,     -1,               VA, 0, 1, 1, 1, HT,     HA,     VT, VA);
    tab[8]  = mk(0,       HT,     -1,               VA, 0, 0, 1, 0, HT,     HA,     VT, VA);
    tab[9]  = mk(TMO + 16, HT,    -1,               0,  0, 0, 0, 1, HT,     HA,     VT, VA);
    tab[10] = mk(0,       HT,     -1,               VA, 0, 0, 1, 1, HT,     HA,     VT, VA);
    tab[11] = mk(0,       HT,     -1,               VA, 0, 0, 1, 1, HT,     HA,     VT, VA);
    repeat (5) @(negedge clk);
    reset = 1;
    for (int i = 0; i < 12; i++) begin
      if (tab[i].stall > 0) begin
        @(negedge clk);
        pxclk_in = 0;
        repeat (tab[i].stall) @(negedge clk);
      end
      drive_frame(tab[i], i, VT, 1);
    end
    drive_frame(mk(0, HT, -1, 2, 0, 0, 1, 1, HT, HA, VT, VA), 12, 5, 0);
    check("queue_before_reset", 12, sb.size(), 0);
    @(negedge clk);
    #2 reset = 0;
    #1;
    check("reset_locked", 12, locked, 0);
    check("reset_err_sticky", 12, err_sticky, 0);
    check("reset_h_total", 12, h_total, 0);
    check("reset_v_active", 12, v_active, 0);
    check("reset_pix_x", 12, pix_x, 0);
    check("reset_pix_valid", 12, pix_valid, 0);
    repeat (3) @(negedge clk);
    reset = 1;
    drive_frame(mk(0, HT, -1, 0, 0, 0, 0, 0, 0, 0, 0, 0), 13, VT, 0);
    check("post_reset_locked", 13, locked, 0);
    check("queue_at_end", 13, sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
